// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1/8O1 framing, with the parity sense set by PARITY_ODD.
module uart_rx #(
  parameter int CLKS_PER_BIT = 234,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxp,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
`ifdef UART_RX_PARITY_EN
  logic          par_bad;
`endif

  // The stop-bit decision resolves, in priority order: framing, then parity,
  // then whether the holding register can take the byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      rx_meta    <= rxp;
      rxs        <= rx_meta;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rxs) begin
              state   <= DATA;
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              par_bad <= 1'b0;
`endif
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= STOP;
            if (rxs != ((^shift) ^ PARITY_ODD)) begin
              par_bad <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`endif

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (!rxs) begin
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              parity_err <= 1'b1;
`endif
            end else if (!rx_valid || rx_ready) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
// Covers reset, handshake, overrun, glitch rejection, framing errors, mid-frame reset and parity framing.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxp;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int passes = 0;

  int cyc = 0;
  int last_start = 0;

  int         load_cnt = 0;
  int         load_cyc = 0;
  int         last_len = 0;
  int         frame_cyc = 0;
  int         overrun_cyc = 0;
  int         parity_cyc = 0;
  logic [7:0] load_data = 8'h00;
  logic       prev_valid = 1'b0;

  int l0, f0, o0, p0;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxp       (rxp),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor samples a few ns after each edge, well ahead of the negedge where the stimulus reads it.
  always @(posedge clk) begin
    #3;
    if (rx_valid && !prev_valid) begin
      load_cnt  = load_cnt + 1;
      load_cyc  = cyc;
      load_data = rx_data;
      last_len  = 0;
    end
    if (rx_valid) last_len = last_len + 1;
    if (frame_err) frame_cyc = frame_cyc + 1;
    if (overrun) overrun_cyc = overrun_cyc + 1;
    if (parity_err) parity_cyc = parity_cyc + 1;
    prev_valid = rx_valid;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; holds each level for one full bit time.
  task automatic send_bit(input logic b);
    rxp = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit);
    last_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^data);
`endif
    send_bit(stop_bit);
    rxp = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic apply_parity_frame(input logic [7:0] data, input logic par_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(par_bit);
    send_bit(1'b1);
    rxp = 1'b1;
  endtask
`endif

  task automatic snapshot();
    l0 = load_cnt;
    f0 = frame_cyc;
    o0 = overrun_cyc;
    p0 = parity_cyc;
  endtask

  initial begin
    reset    = 1'b0;
    rxp      = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_valid", 32'(rx_valid), 32'd0);
    check_output("rst_data", 32'(rx_data), 32'h00);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_frame_err", 32'(frame_err), 32'd0);
    check_output("rst_overrun", 32'(overrun), 32'd0);
    check_output("rst_parity_err", 32'(parity_err), 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] single byte 0x55 with consumer ready");
    rx_ready = 1'b1;
    snapshot();
    apply_stimulus(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    check_output("t1_loads", 32'(load_cnt - l0), 32'd1);
    check_output("t1_data", 32'(load_data), 32'h55);
    check_output("t1_valid_len", 32'(last_len), 32'd1);
    check_output("t1_latency_window", 32'((load_cyc - last_start >= 153) && (load_cyc - last_start <= 155)), 32'd1);
    check_output("t1_valid_cleared", 32'(rx_valid), 32'd0);
    check_output("t1_no_errors", 32'((frame_cyc - f0) + (overrun_cyc - o0)), 32'd0);

    $display("[TB] back-to-back 0xA3, 0x0F with consumer stalled");
    rx_ready = 1'b0;
    snapshot();
    apply_stimulus(8'hA3, 1'b1);
    apply_stimulus(8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    check_output("t2_valid_held", 32'(rx_valid), 32'd1);
    check_output("t2_data_kept", 32'(rx_data), 32'hA3);
    check_output("t2_overrun_once", 32'(overrun_cyc - o0), 32'd1);
    check_output("t2_no_frame_err", 32'(frame_cyc - f0), 32'd0);
    check_output("t2_single_load", 32'(load_cnt - l0), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    check_output("t2_accept_clears", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] 5-cycle low glitch");
    snapshot();
    rxp = 1'b0;
    repeat (4) @(negedge clk);
    check_output("t3_busy_in_start", 32'(busy), 32'd1);
    @(negedge clk);
    rxp = 1'b1;
    repeat (20) @(negedge clk);
    check_output("t3_busy_dropped", 32'(busy), 32'd0);
    check_output("t3_no_load", 32'(load_cnt - l0), 32'd0);
    check_output("t3_valid_low", 32'(rx_valid), 32'd0);
    check_output("t3_no_errors", 32'((frame_cyc - f0) + (overrun_cyc - o0) + (parity_cyc - p0)), 32'd0);

    $display("[TB] 0xC3 with broken stop bit, then 0x3C");
    snapshot();
    apply_stimulus(8'hC3, 1'b0);
    repeat (20) @(negedge clk);
    check_output("t4_frame_err_once", 32'(frame_cyc - f0), 32'd1);
    check_output("t4_no_load", 32'(load_cnt - l0), 32'd0);
    check_output("t4_valid_low", 32'(rx_valid), 32'd0);
    check_output("t4_idle_after", 32'(busy), 32'd0);
    apply_stimulus(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    check_output("t4_recover_valid", 32'(rx_valid), 32'd1);
    check_output("t4_recover_data", 32'(rx_data), 32'h3C);
    check_output("t4_no_extra_errors", 32'((frame_cyc - f0) + (overrun_cyc - o0)), 32'd1);

    $display("[TB] reset during bit 4, then 0x81");
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxp = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("t5_rst_valid", 32'(rx_valid), 32'd0);
    check_output("t5_rst_data", 32'(rx_data), 32'h00);
    check_output("t5_rst_busy", 32'(busy), 32'd0);
    check_output("t5_rst_errors", 32'({frame_err, overrun, parity_err}), 32'd0);
    reset = 1'b1;
    rxp   = 1'b1;
    repeat (30) @(negedge clk);
    check_output("t5_idle_resync", 32'(busy), 32'd0);
    snapshot();
    apply_stimulus(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    check_output("t5_valid", 32'(rx_valid), 32'd1);
    check_output("t5_data", 32'(rx_data), 32'h81);
    check_output("t5_no_errors", 32'((frame_cyc - f0) + (overrun_cyc - o0) + (parity_cyc - p0)), 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    check_output("t5_accept_clears", 32'(rx_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
    $display("[TB] even parity on 0x07");
    snapshot();
    apply_parity_frame(8'h07, 1'b1);
    repeat (4) @(negedge clk);
    check_output("par_good_load", 32'(load_cnt - l0), 32'd1);
    check_output("par_good_data", 32'(load_data), 32'h07);
    check_output("par_good_no_err", 32'(parity_cyc - p0), 32'd0);
    snapshot();
    apply_parity_frame(8'h07, 1'b0);
    repeat (4) @(negedge clk);
    check_output("par_bad_pulse", 32'(parity_cyc - p0), 32'd1);
    check_output("par_bad_no_load", 32'(load_cnt - l0), 32'd0);
    check_output("par_bad_valid_low", 32'(rx_valid), 32'd0);
    check_output("par_bad_no_overrun", 32'(overrun_cyc - o0), 32'd0);
`else
    check_output("parity_err_never", 32'(parity_cyc), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
